lsu_mem_ctrl: RTL and testbench

Load/store controller that drives the word-addressed data memory on behalf of the pipeline's MEM stage. It accepts byte-addressed RV32I load/store requests through a valid/ready handshake and converts them to word accesses. Sub-word stores use read-modify-write. Loaded bytes and halfwords are extracted and sign- or zero-extended. The block sits between the EX/MEM pipeline register and the data memory, and stalls the pipeline while an access is in flight.

---
 rtl/lsu_mem_ctrl.sv | 149 ++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
// RV32I load/store controller: byte-addressed requests to word memory with RMW sub-word stores.
// Optional `LSU_ALIGN_CHECK_EN makes misaligned H/HU/W accesses fault instead of aligning down.
module lsu_mem_ctrl #(
  parameter int DATA      = 32,
  parameter int ADDR      = 32,
  parameter int MEM_DEPTH = 256
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_size,
  input  logic [ADDR-1:0] req_addr,
  input  logic [DATA-1:0] req_wdata,
  output logic            rsp_valid,
  output logic            rsp_err,
  output logic [DATA-1:0] rsp_rdata,
  output logic            mem_we,
  output logic [ADDR-1:0] mem_wa,
  output logic [ADDR-1:0] mem_ra,
  output logic [DATA-1:0] mem_wd,
  input  logic [DATA-1:0] mem_rd
);

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

  state_t          state;
  logic            we_q;
  logic [2:0]      size_q;
  logic [1:0]      lane_q;
  logic [DATA-1:0] wdata_q;

  logic [ADDR-1:0] req_idx;
  logic            size_bad;
  logic            misalign;
  logic            fault;

  function automatic logic [DATA-1:0] load_extend(input logic [DATA-1:0] w,
                                                  input logic [2:0] sz,
                                                  input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (sz[1:0])
      2'b00:   load_extend = sz[2] ? {{(DATA-8){1'b0}}, b} : {{(DATA-8){b[7]}}, b};
      2'b01:   load_extend = sz[2] ? {{(DATA-16){1'b0}}, h} : {{(DATA-16){h[15]}}, h};
      default: load_extend = w;
    endcase
  endfunction

  function automatic logic [DATA-1:0] store_merge(input logic [DATA-1:0] old,
                                                  input logic [DATA-1:0] wd,
                                                  input logic [1:0] sz,
                                                  input logic [1:0] lane);
    logic [DATA-1:0] m;
    m = old;
    case (sz)
      2'b00: m[{lane, 3'b000} +: 8] = wd[7:0];
      2'b01: begin
        if (lane[1]) m[31:16] = wd[15:0];
        else         m[15:0]  = wd[15:0];
      end
      default: m = wd;
    endcase
    return m;
  endfunction

  assign req_idx = {2'b00, req_addr[ADDR-1:2]};

  always_comb begin
    size_bad = req_we ? !(req_size inside {3'b000, 3'b001, 3'b010})
                      :  (req_size inside {3'b011, 3'b110, 3'b111});
    misalign = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
    case (req_size[1:0])
      2'b01:   misalign = req_addr[0];
      2'b10:   misalign = |req_addr[1:0];
      default: misalign = 1'b0;
    endcase
`endif
    fault = size_bad | misalign | (req_idx >= ADDR'(MEM_DEPTH));
  end

  // Faults skip straight to RESP so memory is never touched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      size_q    <= '0;
      lane_q    <= '0;
      wdata_q   <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      mem_we    <= 1'b0;
      mem_wa    <= '0;
      mem_ra    <= '0;
      mem_wd    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q      <= req_we;
            size_q    <= req_size;
            lane_q    <= req_addr[1:0];
            wdata_q   <= req_wdata;
            mem_ra    <= req_idx;
            mem_wa    <= req_idx;
            req_ready <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= fault;
            if (fault) begin
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              state     <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (we_q) begin
            mem_wd <= store_merge(mem_rd, wdata_q, size_q[1:0], lane_q);
            mem_we <= 1'b1;
            state  <= WRITE;
          end else begin
            rsp_rdata <= load_extend(mem_rd, size_q, lane_q);
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        WRITE: begin
          mem_we    <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Randomized self-checking bench for lsu_mem_ctrl against a word-array reference model.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_we;
  logic [31:0] mem_wa, mem_ra, mem_wd, mem_rd;

  logic [31:0] mem     [256] = '{default: 32'h0};
  logic [31:0] ref_mem [256] = '{default: 32'h0};

  int n_checks = 0;
  int n_errors = 0;

  lsu_mem_ctrl #(.DATA(32), .ADDR(32), .MEM_DEPTH(256)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .mem_we(mem_we), .mem_wa(mem_wa), .mem_ra(mem_ra), .mem_wd(mem_wd),
    .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  assign mem_rd = (mem_ra < 32'd256) ? mem[mem_ra[7:0]] : 32'h0;

  always @(posedge clk)
    if (mem_we && mem_wa < 32'd256) mem[mem_wa[7:0]] <= mem_wd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: decides fault, updates ref_mem for stores, returns load value.
  task automatic model(input logic we, input logic [2:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, output logic fault, output logic [31:0] rd);
    int unsigned idx, byte_pos, sh;
    logic [31:0] old, mask, v;
    logic legal;
    idx = a / 4;
    byte_pos = a % 4;
    legal = we ? (sz <= 3'd2) : (sz != 3'd3 && sz != 3'd6 && sz != 3'd7);
    fault = !legal || idx >= 256;
`ifdef LSU_ALIGN_CHECK_EN
    if (((sz == 3'd1 || sz == 3'd5) && (a % 2 != 0)) || (sz == 3'd2 && byte_pos != 0))
      fault = 1'b1;
`endif
    rd = 32'h0;
    if (!fault) begin
      old = ref_mem[idx];
      if (sz == 3'd1 || sz == 3'd5) sh = (byte_pos >= 2) ? 16 : 0;
      else                          sh = byte_pos * 8;
      if (we) begin
        if (sz == 3'd0)      mask = 32'hFF << sh;
        else if (sz == 3'd1) mask = 32'hFFFF << sh;
        else                 begin mask = 32'hFFFF_FFFF; sh = 0; end
        ref_mem[idx] = (old & ~mask) | ((wd << sh) & mask);
      end else begin
        case (sz)
          3'd0, 3'd4: begin
            v = (old >> sh) & 32'hFF;
            if (sz == 3'd0 && v >= 32'h80) v = v + 32'hFFFF_FF00;
          end
          3'd1, 3'd5: begin
            v = (old >> sh) & 32'hFFFF;
            if (sz == 3'd1 && v >= 32'h8000) v = v + 32'hFFFF_0000;
          end
          default: v = old;
        endcase
        rd = v;
      end
    end
  endtask

  task automatic do_req(input logic we, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd_o, output logic err_o);
    logic mf;
    logic [31:0] mrd, wa;
    int lat, wecnt, exp_lat;
    model(we, sz, a, wd, mf, mrd);
    exp_lat = mf ? 1 : (we ? 3 : 2);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    // Junk on the request port while busy must be ignored.
    req_valid = 1'($urandom); req_we = 1'($urandom); req_size = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    lat = 0; wecnt = 0; wa = 32'h0;
    for (int k = 1; k <= 8; k++) begin
      check("busy_ready", {31'b0, req_ready}, 32'h0);
      if (mem_we) begin wecnt++; wa = mem_wa; end
      if (rsp_valid) begin lat = k; break; end
      @(posedge clk); #1;
    end
    check("latency", lat, exp_lat);
    check("rsp_err", {31'b0, rsp_err}, {31'b0, mf});
    check("rsp_rdata", rsp_rdata, (mf || we) ? 32'h0 : mrd);
    check("we_pulses", wecnt, (!mf && we) ? 1 : 0);
    if (we && !mf) check("mem_wa", wa, a >> 2);
    rd_o = rsp_rdata;
    err_o = rsp_err;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("valid_pulse", {31'b0, rsp_valid}, 32'h0);
    check("ready_back", {31'b0, req_ready}, 32'h1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {31'b0, req_ready}, 32'h1);
    check({tag, "_valid"}, {31'b0, rsp_valid}, 32'h0);
    check({tag, "_err"},   {31'b0, rsp_err},   32'h0);
    check({tag, "_rdata"}, rsp_rdata, 32'h0);
    check({tag, "_we"},    {31'b0, mem_we},    32'h0);
    check({tag, "_wa"},    mem_wa, 32'h0);
    check({tag, "_ra"},    mem_ra, 32'h0);
    check({tag, "_wd"},    mem_wd, 32'h0);
  endtask

  logic [31:0] rd;
  logic        er;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("rst");
    @(negedge clk) rst_n = 1'b1;

    do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, rd, er);
    check("sw_mem", mem[4], 32'hDEADBEEF);
    do_req(1'b0, 3'd2, 32'h10, 32'h0, rd, er);
    check("lw_data", rd, 32'hDEADBEEF);

    do_req(1'b1, 3'd2, 32'h10, 32'h11223344, rd, er);
    do_req(1'b1, 3'd0, 32'h11, 32'h000000AA, rd, er);
    check("sb_rmw", mem[4], 32'h1122AA44);
    do_req(1'b0, 3'd0, 32'h11, 32'h0, rd, er);
    check("lb", rd, 32'hFFFFFFAA);
    do_req(1'b0, 3'd4, 32'h11, 32'h0, rd, er);
    check("lbu", rd, 32'h000000AA);

    do_req(1'b1, 3'd2, 32'h10, 32'h0, rd, er);
    do_req(1'b1, 3'd1, 32'h12, 32'h00008001, rd, er);
    check("sh_rmw", mem[4], 32'h80010000);
    do_req(1'b0, 3'd1, 32'h12, 32'h0, rd, er);
    check("lh", rd, 32'hFFFF8001);
    do_req(1'b0, 3'd5, 32'h12, 32'h0, rd, er);
    check("lhu", rd, 32'h00008001);

    do_req(1'b0, 3'd2, 32'h400, 32'h0, rd, er);
    check("oob_err", {31'b0, er}, 32'h1);
    do_req(1'b1, 3'd4, 32'h20, 32'h12345678, rd, er);
    check("bad_size_err", {31'b0, er}, 32'h1);

    do_req(1'b0, 3'd2, 32'h13, 32'h0, rd, er);
`ifdef LSU_ALIGN_CHECK_EN
    check("misalign_err", {31'b0, er}, 32'h1);
`else
    check("misalign_err", {31'b0, er}, 32'h0);
    check("misalign_data", rd, 32'h80010000);
`endif

    for (int i = 0; i < 300; i++) begin
      logic [31:0] idx;
      idx = ($urandom_range(0, 9) == 0) ? 32'd256 + $urandom_range(0, 99) : $urandom_range(0, 15);
      do_req(1'($urandom), 3'($urandom), idx * 4 + $urandom_range(0, 3), $urandom, rd, er);
    end

    // Reset while a store sits in ACCESS: the write must be dropped.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 3'd2; req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("midrst_mem", mem[8], ref_mem[8]);
    check("midrst_ready", {31'b0, req_ready}, 32'h1);
    do_req(1'b0, 3'd2, 32'h20, 32'h0, rd, er);
    check("post_rst_lw", rd, ref_mem[8]);

    for (int i = 0; i < 256; i++) check("final_mem", mem[i], ref_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
